// File: rtl/dht_reader_if.sv
// Result handshake between dht_reader (master) and the reporting path (slave).
interface dht_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] hum_x10;
    logic [15:0] temp_x10;
    logic [1:0]  status;
    logic [1:0]  retries;

    modport master (output out_valid, hum_x10, temp_x10, status, retries,
                    input  out_ready);
    modport slave  (input  out_valid, hum_x10, temp_x10, status, retries,
                    output out_ready);
endinterface

// File: rtl/dht_reader.sv
// DHT11/DHT22 single-wire reader: start pulse, 40-bit decode, checksum retry, scaled results.
// Optional build macro DHT_AUTO_POLL_EN adds a periodic implicit start every POLL_MS.
module dht_reader #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200,
    parameter int GUARD_MS      = 1000,
    parameter int MAX_RETRY     = 3
`ifdef DHT_AUTO_POLL_EN
    , parameter int POLL_MS     = 2000
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic         dq_i,
    output logic         dq_o,
    output logic         dq_oe,
    output logic         busy,
    dht_reader_if.master res
);
    localparam int          DIV       = CLK_HZ / 1_000_000;
    localparam logic [15:0] PRESC_END = 16'(DIV - 1);
    localparam logic [15:0] START_END = 16'(START_LOW_US - 1);
    localparam logic [15:0] THRESH    = 16'(BIT_THRESH_US);
    localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_US);
    localparam logic [15:0] GUARD_END = 16'(GUARD_MS - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
        BIT_LOW, BIT_HIGH, CHECK, RESULT, GUARD
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  dq_sync;
    logic        dq_d, rise, fall;
    logic [15:0] presc, timer, ms_cnt;
    logic        tick, enter, waiting, timed_out;
    logic [39:0] frame;
    logic [5:0]  bit_cnt;
    logic        mode_q, pending, retry_pend, timeout_flag;
    logic [7:0]  retry_cnt;
    logic        req, poll_req, frame_ok, do_retry;
    logic [7:0]  b0, b1, b2, b3, b4, sum;
    logic [15:0] hum_conv, temp_mag, temp_conv;
    logic        temp_neg;

    // Line idles high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_sync <= 2'b11;
            dq_d    <= 1'b1;
        end else begin
            dq_sync <= {dq_sync[0], dq_i};
            dq_d    <= dq_sync[1];
        end
    end

    assign rise  = dq_sync[1] & ~dq_d;
    assign fall  = ~dq_sync[1] & dq_d;
    assign tick  = (presc == PRESC_END);
    assign enter = (state_nx != state);

    // Prescaler restarts with the phase so every phase lasts an exact number of ticks;
    // GUARD is too long for 16 bits of microseconds, so it counts milliseconds instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            timer  <= '0;
            ms_cnt <= '0;
        end else if (enter) begin
            presc  <= '0;
            timer  <= '0;
            ms_cnt <= '0;
        end else if (tick) begin
            presc <= '0;
            if (state == GUARD && timer == 16'd999) begin
                timer  <= '0;
                ms_cnt <= ms_cnt + 16'd1;
            end else begin
                timer <= timer + 16'd1;
            end
        end else begin
            presc <= presc + 16'd1;
        end
    end

`ifdef DHT_AUTO_POLL_EN
    localparam logic [15:0] POLL_END = 16'(POLL_MS - 1);
    logic [15:0] poll_presc, poll_us, poll_ms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_presc <= '0;
            poll_us    <= '0;
            poll_ms    <= '0;
            poll_req   <= 1'b0;
        end else begin
            poll_req <= 1'b0;
            if (poll_presc == PRESC_END) begin
                poll_presc <= '0;
                if (poll_us == 16'd999) begin
                    poll_us <= '0;
                    if (poll_ms == POLL_END) begin
                        poll_ms  <= '0;
                        poll_req <= 1'b1;
                    end else begin
                        poll_ms <= poll_ms + 16'd1;
                    end
                end else begin
                    poll_us <= poll_us + 16'd1;
                end
            end else begin
                poll_presc <= poll_presc + 16'd1;
            end
        end
    end
`else
    assign poll_req = 1'b0;
`endif

    assign req       = start | poll_req;
    assign waiting   = (state == RELEASE) || (state == RESP_LOW) || (state == RESP_HIGH) ||
                       (state == BIT_LOW) || (state == BIT_HIGH);
    assign timed_out = waiting && (timer >= TIMEOUT);

    assign b0       = frame[39:32];
    assign b1       = frame[31:24];
    assign b2       = frame[23:16];
    assign b3       = frame[15:8];
    assign b4       = frame[7:0];
    assign sum      = b0 + b1 + b2 + b3;
    assign frame_ok = !timeout_flag && (sum == b4);
    assign do_retry = !frame_ok && (retry_cnt < RETRY_MAX);

    assign hum_conv  = mode_q ? {b0, b1} : (16'(b0) * 16'd10 + 16'(b1));
    assign temp_mag  = mode_q ? {1'b0, b2[6:0], b3} : (16'(b2) * 16'd10 + {12'd0, b3[3:0]});
    assign temp_neg  = mode_q ? b2[7] : b3[7];
    assign temp_conv = temp_neg ? -temp_mag : temp_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req || pending) state_nx = START_LOW;
            START_LOW: if (tick && timer == START_END) state_nx = RELEASE;
            RELEASE:   if (timed_out) state_nx = CHECK; else if (fall) state_nx = RESP_LOW;
            RESP_LOW:  if (timed_out) state_nx = CHECK; else if (rise) state_nx = RESP_HIGH;
            RESP_HIGH: if (timed_out) state_nx = CHECK; else if (fall) state_nx = BIT_LOW;
            BIT_LOW:   if (timed_out) state_nx = CHECK; else if (rise) state_nx = BIT_HIGH;
            BIT_HIGH:  if (timed_out) state_nx = CHECK;
                       else if (fall) state_nx = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
            CHECK:     state_nx = do_retry ? GUARD : RESULT;
            RESULT:    if (res.out_ready) state_nx = GUARD;
            GUARD:     if (tick && timer == 16'd999 && ms_cnt == GUARD_END)
                           state_nx = retry_pend ? START_LOW : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Transaction bookkeeping, bit capture and the result registers loaded in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame        <= '0;
            bit_cnt      <= '0;
            mode_q       <= 1'b0;
            pending      <= 1'b0;
            retry_pend   <= 1'b0;
            timeout_flag <= 1'b0;
            retry_cnt    <= '0;
            res.hum_x10  <= '0;
            res.temp_x10 <= '0;
            res.status   <= '0;
            res.retries  <= '0;
        end else begin
            if (busy && req) pending <= 1'b1;
            if (timed_out) timeout_flag <= 1'b1;
            case (state)
                IDLE: if (state_nx == START_LOW) begin
                    pending   <= 1'b0;
                    mode_q    <= mode;
                    retry_cnt <= '0;
                end
                START_LOW: begin
                    bit_cnt      <= '0;
                    timeout_flag <= 1'b0;
                    retry_pend   <= 1'b0;
                end
                BIT_HIGH: if (fall && !timed_out) begin
                    frame   <= {frame[38:0], (timer > THRESH)};
                    bit_cnt <= bit_cnt + 6'd1;
                end
                CHECK: if (do_retry) begin
                    retry_cnt  <= retry_cnt + 8'd1;
                    retry_pend <= 1'b1;
                end else begin
                    res.status  <= timeout_flag ? 2'd2 : (frame_ok ? 2'd0 : 2'd1);
                    res.retries <= (retry_cnt >= 8'd3) ? 2'd3 : retry_cnt[1:0];
                    if (frame_ok) begin
                        res.hum_x10  <= hum_conv;
                        res.temp_x10 <= temp_conv;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dq_o          = 1'b0;
    assign dq_oe         = (state == START_LOW);
    assign busy          = (state != IDLE);
    assign res.out_valid = (state == RESULT);
endmodule

// File: tb/tb_dht_reader.sv
// Bench for dht_reader: a timed DHT sensor model, a result predictor and a per-cycle compare process.
`timescale 1ns/1ns
module tb_dht_reader;
    localparam int US       = 1000;
    localparam int CLK_HALF = 250;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic dq_o, dq_oe, busy;
    logic sensorLine = 1'b1;
    logic dqLine;

    int checks = 0;
    int passed = 0;
    logic [39:0] sensorQ[$];
    logic [39:0] plan[$];
    bit          expArmed = 1'b0;
    logic [15:0] expHum = '0;
    logic [15:0] expTemp = '0;
    logic [1:0]  expStatus = '0;
    logic [1:0]  expRetries = '0;
    int expAttempts = 0;
    int attempts = 0;
    int lowCycles = 0;

    assign dqLine = dq_oe ? dq_o : sensorLine;

    dht_reader_if res_if();

    dht_reader #(
        .CLK_HZ(2_000_000), .START_LOW_US(200), .BIT_THRESH_US(40),
        .TIMEOUT_US(200), .GUARD_MS(1), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dq_i(dqLine),
        .dq_o(dq_o), .dq_oe(dq_oe), .busy(busy), .res(res_if)
    );

    always #CLK_HALF clk = ~clk;

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic int byteOf(input logic [39:0] f, input int j);
        return int'((f >> (32 - 8 * j)) & 40'hFF);
    endfunction

    function automatic bit sumOk(input logic [39:0] f);
        int s;
        s = 0;
        for (int j = 0; j < 4; j++) s += byteOf(f, j);
        return (s % 256) == byteOf(f, 4);
    endfunction

    // Outcome of a whole transaction: first good frame wins, missing frames are timeouts.
    function automatic void predict(input bit dht22);
        int st, used, h, t;
        logic [39:0] f;
        st = 2;
        used = 0;
        for (int k = 0; k <= 3; k++) begin
            used = k;
            if (k >= plan.size()) st = 2;
            else if (sumOk(plan[k])) begin st = 0; break; end
            else st = 1;
        end
        expStatus   = 2'(st);
        expRetries  = 2'(used);
        expAttempts = used + 1;
        if (st == 0) begin
            f = plan[used];
            if (dht22) begin
                h = byteOf(f, 0) * 256 + byteOf(f, 1);
                t = (byteOf(f, 2) % 128) * 256 + byteOf(f, 3);
                if (byteOf(f, 2) >= 128) t = -t;
            end else begin
                h = byteOf(f, 0) * 10 + byteOf(f, 1);
                t = byteOf(f, 2) * 10 + byteOf(f, 3) % 16;
                if (byteOf(f, 3) >= 128) t = -t;
            end
            expHum  = 16'(h);
            expTemp = 16'(t);
        end
    endfunction

    task automatic driveFrame(input logic [39:0] f);
        #(20 * US) sensorLine = 1'b0;
        #(80 * US) sensorLine = 1'b1;
        #(80 * US);
        for (int i = 39; i >= 0; i--) begin
            sensorLine = 1'b0;
            #(24 * US) sensorLine = 1'b1;
            if (f[i]) #(58 * US);
            else      #(22 * US);
        end
        sensorLine = 1'b0;
        #(24 * US) sensorLine = 1'b1;
    endtask

    // Sensor answers only a start pulse of plausible length, one queued frame per pulse.
    initial begin : sensorModel
        time tRise;
        logic [39:0] f;
        forever begin
            @(posedge dq_oe);
            attempts++;
            tRise = $time;
            @(negedge dq_oe);
            lowCycles = int'(($time - tRise) / (2 * CLK_HALF));
            if (($time - tRise) >= 150 * US && sensorQ.size() > 0) begin
                f = sensorQ.pop_front();
                driveFrame(f);
            end
        end
    end

    // Whenever a result is presented it must match the prediction, every cycle it is held.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_if.out_valid === 1'b1) begin
            if (expArmed) begin
                checkOutput("model result",
                    {4'd0, res_if.hum_x10, res_if.temp_x10, res_if.status, res_if.retries},
                    {4'd0, expHum, expTemp, expStatus, expRetries});
                if (res_if.out_ready === 1'b1) expArmed = 1'b0;
            end else begin
                checkOutput("spurious out_valid", {39'd0, res_if.out_valid}, 40'd0);
            end
        end
    end

    task automatic applyStimulus(input bit m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launchTxn(input bit dht22);
        predict(dht22);
        sensorQ  = plan;
        attempts = 0;
        expArmed = 1'b1;
        applyStimulus(dht22);
    endtask

    task automatic waitValid(input string name, input int budget);
        int n;
        n = 0;
        while (res_if.out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " out_valid"}, {39'd0, res_if.out_valid}, 40'd1);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " idle"}, {39'd0, busy}, 40'd0);
    endtask

    task automatic checkLiteral(input string name, input logic [15:0] h, input logic [15:0] t,
                                input logic [1:0] s, input logic [1:0] r);
        checkOutput({name, " dut literal"},
            {4'd0, res_if.hum_x10, res_if.temp_x10, res_if.status, res_if.retries}, {4'd0, h, t, s, r});
        checkOutput({name, " model literal"}, {4'd0, expHum, expTemp, expStatus, expRetries},
            {4'd0, h, t, s, r});
    endtask

    initial begin : watchdog
        #(50_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainFlow
        int gap, oeHigh, validDrop;
        res_if.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset dq_oe", {39'd0, dq_oe}, 40'd0);
        checkOutput("reset busy", {39'd0, busy}, 40'd0);
        checkOutput("reset out_valid", {39'd0, res_if.out_valid}, 40'd0);
        checkOutput("reset result", {4'd0, res_if.hum_x10, res_if.temp_x10, res_if.status, res_if.retries}, 40'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] DHT11 frame");
        plan = '{40'h3700190555};
        launchTxn(1'b0);
        waitValid("dht11", 20000);
        checkLiteral("dht11", 16'd550, 16'd255, 2'd0, 2'd0);
        checkOutput("dht11 start low cycles", 40'(lowCycles), 40'd400);
        checkOutput("dht11 attempts", 40'(attempts), 40'(expAttempts));
        waitIdle("dht11", 5000);

        $display("[TB] DHT22 frame, mode toggled mid-frame");
        plan = '{40'h028C806573};
        launchTxn(1'b1);
        repeat (100) @(negedge clk);
        mode = 1'b0;
        waitValid("dht22", 20000);
        checkLiteral("dht22", 16'd652, 16'hFF9B, 2'd0, 2'd0);
        waitIdle("dht22", 5000);

        $display("[TB] two corrupt frames then good");
        plan = '{40'h3C001A0200, 40'h3C001A0201, 40'h3C001A0258};
        launchTxn(1'b0);
        waitValid("retry", 40000);
        checkLiteral("retry", 16'd600, 16'd262, 2'd0, 2'd2);
        checkOutput("retry attempts", 40'(attempts), 40'd3);
        waitIdle("retry", 5000);

        $display("[TB] no sensor response");
        plan.delete();
        launchTxn(1'b0);
        waitValid("timeout", 20000);
        checkLiteral("timeout", 16'd600, 16'd262, 2'd2, 2'd3);
        checkOutput("timeout attempts", 40'(attempts), 40'd4);
        waitIdle("timeout", 5000);

        $display("[TB] stalled consumer with start during RESULT");
        plan = '{40'h01F400FAEF};
        res_if.out_ready = 1'b0;
        launchTxn(1'b1);
        waitValid("stall", 20000);
        checkLiteral("stall", 16'd500, 16'd250, 2'd0, 2'd0);
        applyStimulus(1'b1);
        oeHigh = 0;
        validDrop = 0;
        repeat (500) begin
            @(negedge clk);
            if (dq_oe === 1'b1) oeHigh++;
            if (res_if.out_valid !== 1'b1) validDrop++;
        end
        checkOutput("stall dq_oe quiet", 40'(oeHigh), 40'd0);
        checkOutput("stall valid held", 40'(validDrop), 40'd0);
        @(posedge clk);
        #2 res_if.out_ready = 1'b1;
        @(posedge clk);
        gap = 0;
        @(negedge clk);
        while (dq_oe !== 1'b1 && gap < 5000) begin
            gap++;
            @(negedge clk);
        end
        checkOutput("pending relaunch gap", 40'(gap), 40'd2001);

        $display("[TB] reset during START_LOW");
        repeat (50) @(negedge clk);
        #100 rst_n = 1'b0;
        #1;
        checkOutput("midreset dq_oe", {39'd0, dq_oe}, 40'd0);
        checkOutput("midreset busy", {39'd0, busy}, 40'd0);
        checkOutput("midreset result", {4'd0, res_if.hum_x10, res_if.temp_x10, res_if.status, res_if.retries}, 40'd0);
        expHum  = '0;
        expTemp = '0;
        #100 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        plan = '{40'h28050384B4};
        launchTxn(1'b0);
        waitValid("after reset", 20000);
        checkLiteral("after reset", 16'd405, 16'hFFDE, 2'd0, 2'd0);
        checkOutput("after reset start low cycles", 40'(lowCycles), 40'd400);
        checkOutput("after reset attempts", 40'(attempts), 40'd1);
        waitIdle("after reset", 5000);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
